// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_controller
//  Description : Instruction fetch front end. Walks a program counter through
//                a combinational instruction memory and queues
//                {pc, instruction} pairs in a small first-word-fall-through
//                buffer for the decode stage. Supports start/halt control and
//                redirects that flush the buffer.
//  Ports       : clk, rst_n                - clock, async active-low reset
//                start, halt               - run control
//                redirect_valid/_pc        - branch/jump redirect
//                imem_addr / imem_instr    - combinational instruction memory
//                inst_valid/ready/word/pc  - decode-side valid/ready stream
//                state                     - IDLE=0, FETCH=1, HALTED=2
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
    output logic [1:0]  state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_fetch_pc;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [31:0]     r_buf_pc    [DEPTH];
    logic [31:0]     r_buf_instr [DEPTH];

    logic            w_pop;
    logic            w_push;

    // ------------------------------------------------------------------
    // Handshakes. A full buffer may still accept a new entry when the head
    // leaves in the same cycle, which keeps a streaming pipe bubble-free.
    // ------------------------------------------------------------------
    assign w_pop  = inst_valid && inst_ready;
    assign w_push = (r_state == ST_FETCH) && !halt && !redirect_valid &&
                    ((r_count < c_depth) || w_pop);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. halt dominates start; redirects never move the FSM.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !halt) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (halt) begin
                    w_next_state = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (start && !halt) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch PC, occupancy and pointers. A redirect flushes everything,
    // including an entry that decode accepts in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_tail     <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Buffer storage needs no reset: entries are only visible while count
    // covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_tail]    <= r_fetch_pc;
            r_buf_instr[r_tail] <= imem_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst_word  = inst_valid ? r_buf_instr[r_head] : 32'd0;
    assign inst_pc    = inst_valid ? r_buf_pc[r_head]    : 32'd0;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Directed self-checking bench for fetch_controller. The
//                instruction memory model returns its own word index
//                (mem[i] = i).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_controller #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc),
        .state          (state)
    );

    // mem[i] = i, word index = addr[22:2]
    assign imem_instr = {11'd0, imem_addr[22:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        inst_ready     = 1'b0;

        // ---------------- reset state ----------------
        tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr",  imem_addr, 32'd0);
        check("rst_pc",    inst_pc, 32'd0);
        check("rst_word",  inst_word, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_hold", {30'd0, state}, 32'd0);

        // halt beats start in IDLE
        start = 1'b1;
        halt  = 1'b1;
        tick();
        check("idle_halt_prio", {30'd0, state}, 32'd0);
        halt = 1'b0;

        // ---------------- stream ----------------
        inst_ready = 1'b1;
        tick();                       // start sampled -> FETCH
        start = 1'b0;
        check("st_fetch",   {30'd0, state}, 32'd1);
        check("st_valid0",  {31'd0, inst_valid}, 32'd0);
        tick();                       // first push
        for (int i = 0; i < 5; i++) begin
            check("st_valid", {31'd0, inst_valid}, 32'd1);
            check("st_pc",    inst_pc, 32'(i * 4));
            check("st_word",  inst_word, 32'(i));
            tick();
        end

        // ---------------- backpressure ----------------
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0000;
        tick();
        redirect_valid = 1'b0;
        check("bp_flush_valid", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("bp_addr_hold", imem_addr, 32'h10);
        check("bp_head_pc",   inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_pc", inst_pc, 32'(i * 4));
            tick();
        end

        // ---------------- redirect while full ----------------
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rd_full_valid", {31'd0, inst_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid0", {31'd0, inst_valid}, 32'd0);
        check("rd_addr",   imem_addr, 32'h100);
        tick();
        check("rd_pc0", inst_pc, 32'h100);
        inst_ready = 1'b1;
        tick();
        check("rd_pc1", inst_pc, 32'h104);

        // ---------------- halt with 3 buffered ----------------
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("h_state",  {30'd0, state}, 32'd2);
        check("h_addr",   imem_addr, 32'h20C);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("h_drain_pc", inst_pc, 32'h200 + 32'(i * 4));
            tick();
        end
        check("h_empty",      {31'd0, inst_valid}, 32'd0);
        check("h_addr_held",  imem_addr, 32'h20C);
        check("h_state_keep", {30'd0, state}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("h_resume_state", {30'd0, state}, 32'd1);
        tick();
        check("h_resume_pc", inst_pc, 32'h20C);

        // ---------------- wrap ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("w_valid0", {31'd0, inst_valid}, 32'd0);
        tick();
        check("w_pc_top",   inst_pc, 32'hFFFF_FFFC);
        check("w_word_top", inst_word, 32'h001F_FFFF);
        tick();
        check("w_pc_zero",   inst_pc, 32'h0);
        check("w_word_zero", inst_word, 32'h0);

        // ---------------- async reset mid-stream ----------------
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, inst_valid}, 32'd0);
        check("ar_state", {30'd0, state}, 32'd0);
        check("ar_addr",  imem_addr, 32'h0);
        check("ar_pc",    inst_pc, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("ar_post_valid", {31'd0, inst_valid}, 32'd0);
        check("ar_post_state", {30'd0, state}, 32'd0);
        check("ar_post_addr",  imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: fetch-buffer entries; power of two, at least 2.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begin or resume fetching.
REQ-006 The block SHALL have port halt, input, 1 bit: stop issuing fetches.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect strobe.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: redirect target.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: address to the combinational instruction memory (word index = addr[22:2]).
REQ-010 The block SHALL have port imem_instr, input, 32 bits: instruction word returned for imem_addr in the same cycle.
REQ-011 The block SHALL have port inst_valid, output, 1 bit: buffer head valid.
REQ-012 The block SHALL have port inst_ready, input, 1 bit: decode accepts the head.
REQ-013 The block SHALL have port inst_word, output, 32 bits: head instruction.
REQ-014 The block SHALL have port inst_pc, output, 32 bits: address of the head instruction.
REQ-015 The block SHALL have port state, output, 2 bits: IDLE=0, FETCH=1, HALTED=2; encoding 3 is never driven.

Function
REQ-016 imem_addr SHALL equal the fetch_pc register at all times.
REQ-017 Pop SHALL occur when inst_valid && inst_ready; inst_valid SHALL be 1 exactly when count != 0.
REQ-018 When count == 0, inst_word and inst_pc SHALL be 0; otherwise they SHALL be driven from the head entry (first-word fall-through).
REQ-019 Push SHALL occur when state == FETCH, halt == 0, redirect_valid == 0, and (count < DEPTH or a pop occurs in the same cycle).
REQ-020 A push SHALL store {fetch_pc, imem_instr} at the tail and set fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; with count == DEPTH, a push SHALL occur only with a same-cycle pop.
REQ-022 Latency: an instruction pushed at edge N SHALL appear on inst_word after edge N when the buffer was empty, with no bubble when back-to-back.
REQ-023 While no push occurs, fetch_pc SHALL hold, keeping imem_addr stable.
REQ-024 redirect_valid SHALL, in any state:
  - set fetch_pc <= {redirect_pc[31:2], 2'b00};
  - set count, head and tail <= 0;
  - suppress the push.
REQ-025 A pop coinciding with a redirect SHALL count as consumed by decode; the buffer is still fully flushed.
REQ-026 FSM transitions SHALL be:
  - IDLE -> FETCH on start;
  - FETCH -> HALTED on halt;
  - HALTED -> FETCH on start && !halt;
  - halt SHALL have priority over start;
  - redirect SHALL not change state.
REQ-027 In IDLE and HALTED, buffered entries SHALL still drain via pops; no pushes SHALL occur.
REQ-028 The internal count register SHALL be $clog2(DEPTH)+1 bits wide; read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While rst_n == 0, the block SHALL immediately hold:
  - state = IDLE;
  - fetch_pc = RESET_PC (so imem_addr = RESET_PC);
  - count, head and tail = 0;
  - inst_valid = 0, inst_word = 0, inst_pc = 0.
REQ-030 Reset asserted mid-stream SHALL discard all buffered entries, with no residual output after release.
REQ-031 After rst_n deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-032 Stream: mem[i] = i, start pulsed 1 cycle, inst_ready = 1 -> inst_valid rises after the 2nd edge following start; inst_pc = 0, 4, 8, ...; inst_word = 0, 1, 2, ...; one per cycle.
REQ-033 Backpressure: inst_ready = 0 -> count saturates at 4 and imem_addr holds 0x10; ready = 1 -> inst_pc = 0x0, 0x4, 0x8, 0xC, 0x10 with no gap or duplicate.
REQ-034 Redirect while full, redirect_pc = 0x103 -> inst_valid = 0 next cycle, then inst_pc = 0x100, 0x104.
REQ-035 halt with 3 entries buffered -> state = 2 and 3 entries drain; start resumes with inst_pc continuing from the held fetch_pc.
REQ-036 Wrap: redirect_pc = 0xFFFFFFFC -> inst_pc = 0xFFFFFFFC, then 0x00000000.
REQ-037 rst_n pulsed low mid-stream, asynchronously between edges -> inst_valid = 0, state = 0 and imem_addr = RESET_PC before the next edge.
